// File: rtl/fmdll_pkg.sv
// Shared types and default widths for the FMDLL phase detector.
package fmdll_pkg;

  // Phase-detector sequencing: blank while the code settles, gather votes, emit one decision.
  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2
  } pd_state_t;

  // Direction of one majority decision; TIE only occurs with an even window size.
  typedef enum logic [1:0] {
    DIR_UP  = 2'd0,
    DIR_DN  = 2'd1,
    DIR_TIE = 2'd2
  } dir_t;

  localparam int CODE_W_DEF   = 10;
  localparam int M_W_DEF      = 2;
  localparam int N_W_DEF      = 4;
  localparam int VOTE_N_DEF   = 5;
  localparam int SETTLE_N_DEF = 2;
  localparam int LOCK_N_DEF   = 8;

endpackage

// File: rtl/pd_lock_det.sv
// Lock tracker: counts consecutive alternating decisions and drops lock after two repeats in a row.
module pd_lock_det
  import fmdll_pkg::*;
#(
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic clk_ext,
  input  logic Reset_PD,
  input  logic dec_valid,
  input  dir_t dec_dir,
  output logic LOCK
);

  localparam int AW = $clog2(LOCK_N + 1);

  logic [AW-1:0] alt_cnt_q, alt_cnt_d;
  dir_t          last_dir_q, last_dir_d;
  logic          have_last_q, have_last_d;
  logic          rep_q, rep_d;
  logic          lock_q, lock_d;
  logic          opposite_s;

  // Next-state for alternation count, repeat flag and lock on each decision.
  always_comb begin
    alt_cnt_d   = alt_cnt_q;
    last_dir_d  = last_dir_q;
    have_last_d = have_last_q;
    rep_d       = rep_q;
    lock_d      = lock_q;
    // A tie is never "opposite", so it always behaves as a repeat.
    opposite_s  = have_last_q && (dec_dir != DIR_TIE) && (last_dir_q != DIR_TIE) &&
                  (dec_dir != last_dir_q);
    if (dec_valid) begin
      last_dir_d  = dec_dir;
      have_last_d = 1'b1;
      if (!have_last_q) begin
        // First decision after reset has nothing to alternate against.
        alt_cnt_d = {AW{1'b0}};
        rep_d     = 1'b0;
      end else if (opposite_s) begin
        rep_d = 1'b0;
        if (alt_cnt_q < AW'(LOCK_N)) begin
          alt_cnt_d = alt_cnt_q + AW'(1);
        end else begin
          alt_cnt_d = alt_cnt_q;
        end
        if (alt_cnt_q >= AW'(LOCK_N - 1)) begin
          lock_d = 1'b1;
        end else begin
          lock_d = lock_q;
        end
      end else begin
        alt_cnt_d = {AW{1'b0}};
        rep_d     = 1'b1;
        if (rep_q) begin
          lock_d = 1'b0;
        end else begin
          lock_d = lock_q;
        end
      end
    end else begin
      rep_d = rep_q;
    end
  end

  // Lock-tracker state registers with synchronous reset.
  always_ff @(posedge clk_ext) begin
    if (Reset_PD) begin
      alt_cnt_q   <= {AW{1'b0}};
      last_dir_q  <= DIR_TIE;
      have_last_q <= 1'b0;
      rep_q       <= 1'b0;
      lock_q      <= 1'b0;
    end else begin
      alt_cnt_q   <= alt_cnt_d;
      last_dir_q  <= last_dir_d;
      have_last_q <= have_last_d;
      rep_q       <= rep_d;
      lock_q      <= lock_d;
    end
  end

  assign LOCK = lock_q;

endmodule

// File: rtl/pd_vote_lock.sv
// FMDLL phase detector: samples clk_out at the (M,1) counter point, majority-votes
// VOTE_N samples into UP/DN pulses, blanks while the delay code settles, tracks lock.
module pd_vote_lock
  import fmdll_pkg::*;
#(
  parameter int CODE_W   = CODE_W_DEF,
  parameter int M_W      = M_W_DEF,
  parameter int N_W      = N_W_DEF,
  parameter int VOTE_N   = VOTE_N_DEF,
  parameter int SETTLE_N = SETTLE_N_DEF,
  parameter int LOCK_N   = LOCK_N_DEF
) (
  input  logic              clk_ext,
  input  logic              Reset_PD,
  input  logic              clk_out,
  input  logic [M_W-1:0]    M_counter,
  input  logic [N_W-1:0]    N_counter,
  input  logic [M_W-1:0]    M,
  input  logic [N_W-1:0]    N,
  input  logic [CODE_W-1:0] Q,
  input  logic [CODE_W-1:0] Q_next,
  output logic              UP,
  output logic              DN,
  output logic              COMP,
  output logic              LOCK,
  output logic              busy
);

  localparam int VW = $clog2(VOTE_N + 1);
  localparam int SW = $clog2(SETTLE_N + 1);
  localparam logic [VW:0] VOTE_N_X = (VW + 1)'(VOTE_N);

  logic          sync1_q, s_out_q, cmp_q, chg_q;
  logic          cmp_evt_s, code_chg_s;
  pd_state_t     state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [VW-1:0] samples_q, samples_d, ones_q, ones_d, ones_inc_s;
  logic [VW:0]   twice_s;
  logic          up_q, up_d, dn_q, dn_d, comp_q, comp_d, busy_q;
  logic          dec_valid_s;
  dir_t          dec_dir_s;
  logic          unused_n_s;

  // The (M,N) window-end marker carries no behaviour in this detector.
  assign unused_n_s = ^N;

  // A single equality test already folds the legacy M_counter==1 point into M==1.
  assign cmp_evt_s  = (M_counter == M) && (N_counter == N_W'(1));
  assign code_chg_s = (Q != Q_next);

  // Two-flop synchroniser for clk_out and one-cycle alignment of the compare event.
  always_ff @(posedge clk_ext) begin
    if (Reset_PD) begin
      sync1_q <= 1'b0;
      s_out_q <= 1'b0;
      cmp_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= clk_out;
      s_out_q <= sync1_q;
      cmp_q   <= cmp_evt_s;
      chg_q   <= cmp_evt_s & code_chg_s;
    end
  end

  // FSM next state, vote accumulation and decision; the decision is resolved as the
  // final sample lands so the registered pulse is high during the DECIDE cycle.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    samples_d   = samples_q;
    ones_d      = ones_q;
    up_d        = 1'b0;
    dn_d        = 1'b0;
    comp_d      = comp_q;
    dec_valid_s = 1'b0;
    dec_dir_s   = DIR_TIE;
    ones_inc_s  = ones_q + VW'(s_out_q);
    twice_s     = {ones_inc_s, 1'b0};
    case (state_q)
      SETTLE: begin
        if (cmp_q) begin
          if (chg_q) begin
            settle_d = SW'(SETTLE_N);
          end else if (settle_q <= SW'(1)) begin
            state_d   = COLLECT;
            settle_d  = {SW{1'b0}};
            samples_d = {VW{1'b0}};
            ones_d    = {VW{1'b0}};
          end else begin
            settle_d = settle_q - SW'(1);
          end
        end else begin
          settle_d = settle_q;
        end
      end
      COLLECT: begin
        if (cmp_q) begin
          if (chg_q) begin
            // Code moved under us: drop this sample and the partial window.
            state_d   = SETTLE;
            settle_d  = SW'(SETTLE_N);
            samples_d = {VW{1'b0}};
            ones_d    = {VW{1'b0}};
          end else if (samples_q == VW'(VOTE_N - 1)) begin
            state_d     = DECIDE;
            samples_d   = samples_q + VW'(1);
            ones_d      = ones_inc_s;
            dec_valid_s = 1'b1;
            if (twice_s > VOTE_N_X) begin
              dn_d      = 1'b1;
              comp_d    = 1'b1;
              dec_dir_s = DIR_DN;
            end else if (twice_s < VOTE_N_X) begin
              up_d      = 1'b1;
              comp_d    = 1'b0;
              dec_dir_s = DIR_UP;
            end else begin
              dec_dir_s = DIR_TIE;
            end
          end else begin
            samples_d = samples_q + VW'(1);
            ones_d    = ones_inc_s;
          end
        end else begin
          samples_d = samples_q;
        end
      end
      DECIDE: begin
        state_d   = COLLECT;
        samples_d = {VW{1'b0}};
        ones_d    = {VW{1'b0}};
      end
      default: begin
        state_d   = SETTLE;
        settle_d  = SW'(SETTLE_N);
        samples_d = {VW{1'b0}};
        ones_d    = {VW{1'b0}};
      end
    endcase
  end

  // FSM, vote counters and registered outputs.
  always_ff @(posedge clk_ext) begin
    if (Reset_PD) begin
      state_q   <= SETTLE;
      settle_q  <= SW'(SETTLE_N);
      samples_q <= {VW{1'b0}};
      ones_q    <= {VW{1'b0}};
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      comp_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      samples_q <= samples_d;
      ones_q    <= ones_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      comp_q    <= comp_d;
      busy_q    <= (state_d == SETTLE);
    end
  end

  pd_lock_det #(
    .LOCK_N(LOCK_N)
  ) u_lock (
    .clk_ext  (clk_ext),
    .Reset_PD (Reset_PD),
    .dec_valid(dec_valid_s),
    .dec_dir  (dec_dir_s),
    .LOCK     (LOCK)
  );

  assign UP   = up_q;
  assign DN   = dn_q;
  assign COMP = comp_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_pd_vote_lock.sv
// Directed bench for pd_vote_lock: dut_a uses VOTE_N=5, dut_b uses VOTE_N=4 for tie cases.
module tb_pd_vote_lock;

  logic       clk_ext = 1'b0;
  logic       Reset_PD;
  logic       clk_out_a, clk_out_b;
  logic [1:0] M_counter, M;
  logic [3:0] N_counter, N;
  logic [9:0] Q, Q_next;
  logic       up_a, dn_a, comp_a, lock_a, busy_a;
  logic       up_b, dn_b, comp_b, lock_b, busy_b;
  logic [14:0] av, bv;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_ext = ~clk_ext;

  pd_vote_lock dut_a (
    .clk_ext(clk_ext), .Reset_PD(Reset_PD), .clk_out(clk_out_a),
    .M_counter(M_counter), .N_counter(N_counter), .M(M), .N(N),
    .Q(Q), .Q_next(Q_next),
    .UP(up_a), .DN(dn_a), .COMP(comp_a), .LOCK(lock_a), .busy(busy_a)
  );

  pd_vote_lock #(.VOTE_N(4)) dut_b (
    .clk_ext(clk_ext), .Reset_PD(Reset_PD), .clk_out(clk_out_b),
    .M_counter(M_counter), .N_counter(N_counter), .M(M), .N(N),
    .Q(Q), .Q_next(Q_next),
    .UP(up_b), .DN(dn_b), .COMP(comp_b), .LOCK(lock_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_alt(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One compare event: settle clk_out through the synchroniser, pulse the (M,1) point,
  // return on the negedge where a resulting pulse would be visible.
  task automatic evt(input logic a, input logic b, input logic chg);
    @(negedge clk_ext);
    clk_out_a = a;
    clk_out_b = b;
    Q_next    = chg ? 10'd101 : 10'd100;
    repeat (3) @(negedge clk_ext);
    M_counter = 2'd2;
    N_counter = 4'd1;
    @(negedge clk_ext);
    M_counter = 2'd0;
    N_counter = 4'd0;
    Q_next    = 10'd100;
    @(negedge clk_ext);
  endtask

  // Five events for dut_a; bit i is the clk_out level at the i-th event.
  task automatic wnd(input logic [4:0] pat);
    for (int i = 0; i < 5; i++) evt(pat[i], 1'b0, 1'b0);
  endtask

  initial begin
    Reset_PD  = 1'b1;
    clk_out_a = 1'b0;
    clk_out_b = 1'b0;
    M = 2'd2; N = 4'd4;
    M_counter = 2'd0; N_counter = 4'd0;
    Q = 10'd100; Q_next = 10'd100;
    repeat (3) @(negedge clk_ext);
    chk("rst_up", up_a, 1'b0);
    chk("rst_dn", dn_a, 1'b0);
    chk("rst_comp", comp_a, 1'b0);
    chk("rst_lock", lock_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    Reset_PD = 1'b0;

    // Two blanked events.
    evt(1'b1, 1'b1, 1'b0);
    chk("settle1_busy", busy_a, 1'b1);
    evt(1'b1, 1'b1, 1'b0);
    chk("settle2_busy", busy_a, 1'b0);

    // Events 3..17: dut_a windows DN / UP(2 ones) / DN(3 ones); dut_b DN / UP / tie.
    av = 15'b010110101011111;
    bv = 15'b000001100001111;
    for (int i = 0; i < 15; i++) begin
      evt(av[i], bv[i], 1'b0);
      case (i + 3)
        6: begin
          chk("b_w1_dn", dn_b, 1'b1);
          chk("b_w1_comp", comp_b, 1'b1);
          chk("a_ev6_dn", dn_a, 1'b0);
        end
        7: begin
          chk("a_d1_dn", dn_a, 1'b1);
          chk("a_d1_up", up_a, 1'b0);
          chk("a_d1_comp", comp_a, 1'b1);
        end
        8: chk("a_pulse_width", dn_a, 1'b0);
        10: begin
          chk("b_w2_up", up_b, 1'b1);
          chk("b_w2_comp", comp_b, 1'b0);
          chk_alt("b_w2_alt", dut_b.u_lock.alt_cnt_q, 4'd1);
        end
        12: begin
          chk("a_d2_up", up_a, 1'b1);
          chk("a_d2_dn", dn_a, 1'b0);
          chk("a_d2_comp", comp_a, 1'b0);
        end
        14: begin
          chk("b_tie_up", up_b, 1'b0);
          chk("b_tie_dn", dn_b, 1'b0);
          chk("b_tie_comp", comp_b, 1'b0);
          chk_alt("b_tie_alt", dut_b.u_lock.alt_cnt_q, 4'd0);
        end
        17: begin
          chk("a_d3_dn", dn_a, 1'b1);
          chk("a_d3_comp", comp_a, 1'b1);
        end
        default: ;
      endcase
    end

    // D4..D9 keep alternating; lock arrives with the 8th alternation (D9).
    for (int k = 0; k < 6; k++) begin
      wnd((k % 2 == 0) ? 5'b00000 : 5'b11111);
      if (k == 4) chk("lock_before_8th", lock_a, 1'b0);
    end
    chk("lock_at_8th", lock_a, 1'b1);
    wnd(5'b11111);
    chk("repeat1_dn", dn_a, 1'b1);
    chk("repeat1_lock_kept", lock_a, 1'b1);
    wnd(5'b11111);
    chk("repeat2_lock_drop", lock_a, 1'b0);

    // Code change on the 4th sample of a window.
    for (int i = 0; i < 3; i++) evt(1'b1, 1'b0, 1'b0);
    evt(1'b1, 1'b0, 1'b1);
    chk("chg_no_up", up_a, 1'b0);
    chk("chg_no_dn", dn_a, 1'b0);
    chk("chg_busy", busy_a, 1'b1);
    evt(1'b0, 1'b0, 1'b0);
    chk("chg_busy_ev1", busy_a, 1'b1);
    evt(1'b0, 1'b0, 1'b0);
    chk("chg_busy_ev2", busy_a, 1'b0);
    wnd(5'b00111);
    chk("fresh_window_dn", dn_a, 1'b1);

    // Relock with 8 alternations starting from UP, then reset mid-window.
    for (int k = 0; k < 8; k++) begin
      wnd((k % 2 == 0) ? 5'b00000 : 5'b11111);
      if (k == 6) chk("relock_not_yet", lock_a, 1'b0);
    end
    chk("relock", lock_a, 1'b1);
    evt(1'b1, 1'b0, 1'b0);
    evt(1'b1, 1'b0, 1'b0);
    @(negedge clk_ext);
    Reset_PD = 1'b1;
    @(negedge clk_ext);
    Reset_PD = 1'b0;
    chk("midrst_up", up_a, 1'b0);
    chk("midrst_dn", dn_a, 1'b0);
    chk("midrst_comp", comp_a, 1'b0);
    chk("midrst_lock", lock_a, 1'b0);
    chk("midrst_busy", busy_a, 1'b0);
    evt(1'b1, 1'b0, 1'b0);
    chk("midrst_settle_busy", busy_a, 1'b1);
    evt(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) evt(1'b1, 1'b0, 1'b0);
    chk("midrst_no_stale_dn", dn_a, 1'b0);
    evt(1'b1, 1'b0, 1'b0);
    chk("midrst_first_dn", dn_a, 1'b1);
    chk("midrst_first_lock", lock_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
